zero_scan_ctrl: RTL and testbench
=================================

Name: zero_scan_ctrl

Overview:
Frame-level controller that sequences the 8-bit zero/ones detection datapath over a stream of bytes. It accepts a frame of LEN bytes through a valid/ready handshake and classifies each byte as all-zero (8'h00), all-one (8'hFF) or mixed. It accumulates per-frame statistics, tracks the longest run of consecutive all-zero bytes and raises a sticky alarm when that run reaches a threshold. It sits between a byte source (FIFO or bus slave) and the status/interrupt logic.

Parameters:
RUN_TH, 4, consecutive all-zero byte count that sets run_alarm (legal range 1..255)
CNT_W, 8, width of frame length and all statistic counters

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  one-cycle pulse; begins a frame when busy=0
len  input  CNT_W  frame length in bytes, sampled on accepted start
in_data  input  8  byte under test
in_valid  input  1  in_data valid
in_ready  output  1  controller accepts a byte this cycle
busy  output  1  frame in progress (SCAN or REPORT)
done  output  1  one-cycle pulse at frame end
zero_cnt  output  CNT_W  number of 8'h00 bytes in the frame
ones_cnt  output  CNT_W  number of 8'hFF bytes in the frame
max_zrun  output  CNT_W  longest run of consecutive 8'h00 bytes
run_alarm  output  1  sticky; set when the current zero run reaches RUN_TH

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, internal byte counter and current-run counter 0.
- FSM states: IDLE, SCAN, REPORT.
- IDLE: in_ready=0, busy=0. Accepted start (start=1 in IDLE):
  - latch len;
  - clear zero_cnt, ones_cnt, max_zrun, run_alarm, byte counter and run counter on the next edge;
  - go to SCAN if len!=0, otherwise go directly to REPORT.
- SCAN: in_ready=1, busy=1. A byte is accepted on an edge where in_valid=1 and in_ready=1. Per accepted byte, all updates register on that edge:
  - byte==8'h00: zero_cnt+1; run+1; max_zrun=max(max_zrun, run+1); if run+1==RUN_TH, set run_alarm.
  - byte==8'hFF: ones_cnt+1; run=0.
  - otherwise: run=0.
  - byte counter +1. When the accepted byte is byte number len, go to REPORT.
- in_valid=0 in SCAN: hold all state; there is no timeout.
- REPORT: lasts one cycle. done=1, busy=1, in_ready=0. Then go to IDLE.
- Statistics are valid from the done cycle and are held unchanged until the next accepted start.
- run_alarm is sticky across the rest of the frame and the following IDLE; only a new start or reset clears it.
- Latency: done asserts exactly one cycle after the edge that accepted the last byte. For len=0, done asserts one cycle after start. Minimum frame time is len+1 cycles from the first in_ready.
- start while busy=1 is ignored and has no effect on len or the statistics.
- start and the final byte acceptance in the same cycle: start is ignored.
- Counters never overflow: len is at most 2^CNT_W-1, so every count is at most len. The run counter also saturates at 2^CNT_W-1 for robustness.
- in_data is don't-care when in_valid=0. in_data is never sampled outside SCAN.
- rst_n low mid-frame: immediate return to IDLE with all outputs 0. No done is generated for the aborted frame.

Test Plan:
- Reset then idle: rst_n low 3 cycles then high, no start -> all outputs 0, in_ready=0, busy=0.
- Mixed frame: start len=6, bytes 00,FF,00,00,EB,01 continuous -> done one cycle after the 6th accept; zero_cnt=3, ones_cnt=1, max_zrun=2, run_alarm=0.
- Alarm with RUN_TH=4: len=8, bytes 00,00,00,00,00,FF,00,FF -> run_alarm rises the cycle after the 4th 00 and stays high; zero_cnt=6, ones_cnt=2, max_zrun=5.
- Backpressure gaps: len=3, in_valid toggled 1,0,0,1,0,1 with bytes FF,FF,00 -> only 3 accepts, stats frozen during gaps; ones_cnt=2, zero_cnt=1, done 1 cycle after the last accept.
- Boundaries: start len=0 -> done on the next cycle, all stats 0, in_ready never 1. start pulsed mid-frame -> ignored, original len honoured. Back-to-back frames -> stats cleared the cycle after the second start.
- Async reset mid-frame: assert rst_n low after 2 of 5 bytes -> outputs 0 immediately with no clock edge, no done. The next start len=2 with bytes 00,00 -> zero_cnt=2, max_zrun=2.

Source files
------------

// File: rtl/zero_scan_ctrl.sv
// rtl/zero_scan_ctrl.sv - frame controller classifying bytes as all-zero, all-one or mixed with zero-run tracking
module zero_scan_ctrl #(
    parameter int RUN_TH = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] zero_cnt,
    output logic [CNT_W-1:0] ones_cnt,
    output logic [CNT_W-1:0] max_zrun,
    output logic             run_alarm
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RUN_TH_C = CNT_W'(RUN_TH);

    state_t           state;
    state_t           state_nxt;

    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] run_cnt;

    logic             start_acc;
    logic             accept;
    logic             last_byte;
    logic             is_zero;
    logic             is_ones;
    logic [CNT_W-1:0] byte_cnt_inc;
    logic [CNT_W-1:0] run_inc;

    // Start is only honoured from IDLE; bytes are only sampled in SCAN.
    assign start_acc    = (state == IDLE) && start;
    assign accept       = (state == SCAN) && in_valid;
    assign is_zero      = (in_data == 8'h00);
    assign is_ones      = (in_data == 8'hFF);
    assign byte_cnt_inc = byte_cnt + ONE;
    // Run counter saturates rather than wrapping back to zero.
    assign run_inc      = (run_cnt == CNT_MAX) ? CNT_MAX : run_cnt + ONE;
    assign last_byte    = accept && (byte_cnt_inc == len_q);

    assign in_ready = (state == SCAN);
    assign busy     = (state != IDLE);
    assign done     = (state == REPORT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a zero-length frame skips SCAN entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? REPORT : SCAN;
                end
            end
            SCAN: begin
                if (last_byte) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame length latch, byte/run counters and per-frame statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            byte_cnt  <= '0;
            run_cnt   <= '0;
            zero_cnt  <= '0;
            ones_cnt  <= '0;
            max_zrun  <= '0;
            run_alarm <= 1'b0;
        end else if (start_acc) begin
            len_q     <= len;
            byte_cnt  <= '0;
            run_cnt   <= '0;
            zero_cnt  <= '0;
            ones_cnt  <= '0;
            max_zrun  <= '0;
            run_alarm <= 1'b0;
        end else if (accept) begin
            byte_cnt <= byte_cnt_inc;
            if (is_zero) begin
                zero_cnt <= zero_cnt + ONE;
                run_cnt  <= run_inc;
                if (run_inc > max_zrun) begin
                    max_zrun <= run_inc;
                end
                if (run_inc == RUN_TH_C) begin
                    run_alarm <= 1'b1;
                end
            end else if (is_ones) begin
                ones_cnt <= ones_cnt + ONE;
                run_cnt  <= '0;
            end else begin
                run_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_zero_scan_ctrl.sv
// tb/tb_zero_scan_ctrl.sv - directed self-checking bench for zero_scan_ctrl
module tb_zero_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [7:0] zero_cnt;
    logic [7:0] ones_cnt;
    logic [7:0] max_zrun;
    logic       run_alarm;

    int n_checks = 0;
    int n_fail   = 0;

    zero_scan_ctrl #(.RUN_TH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .zero_cnt  (zero_cnt),
        .ones_cnt  (ones_cnt),
        .max_zrun  (max_zrun),
        .run_alarm (run_alarm)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 8'hAA;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({in_ready, busy, done, run_alarm} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {in_ready, busy, done, run_alarm});
        end
        n_checks++;
        if ({zero_cnt, ones_cnt, max_zrun} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h expected 000000", {zero_cnt, ones_cnt, max_zrun});
        end
    endtask

    task automatic test_mixed();
        logic [7:0] bytes [6] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'hEB, 8'h01};
        do_start(8'd6);
        n_checks++;
        if ({in_ready, busy, done} !== 3'b110) begin
            n_fail++;
            $display("FAIL mixed_scan_flags: got %b expected 110", {in_ready, busy, done});
        end
        for (int i = 0; i < 6; i++) begin
            send_byte(bytes[i]);
            if (i == 4) begin
                n_checks++;
                if (done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mixed_early_done: got %b expected 0", done);
                end
            end
        end
        n_checks++;
        if ({done, busy, in_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL mixed_report_flags: got %b expected 110", {done, busy, in_ready});
        end
        n_checks++;
        if ({zero_cnt, ones_cnt, max_zrun, 7'd0, run_alarm} !== {8'd3, 8'd1, 8'd2, 8'd0}) begin
            n_fail++;
            $display("FAIL mixed_stats: got z=%0d o=%0d m=%0d a=%0d expected z=3 o=1 m=2 a=0",
                     zero_cnt, ones_cnt, max_zrun, run_alarm);
        end
        tick();
        n_checks++;
        if ({done, busy, zero_cnt, ones_cnt, max_zrun} !== {2'b00, 8'd3, 8'd1, 8'd2}) begin
            n_fail++;
            $display("FAIL mixed_idle_hold: got d=%b b=%b z=%0d o=%0d m=%0d expected d=0 b=0 z=3 o=1 m=2",
                     done, busy, zero_cnt, ones_cnt, max_zrun);
        end
    endtask

    task automatic test_alarm();
        logic [7:0] bytes [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF};
        logic       exp_a [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_start(8'd8);
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i]);
            n_checks++;
            if (run_alarm !== exp_a[i]) begin
                n_fail++;
                $display("FAIL alarm_after_byte%0d: got %b expected %b", i, run_alarm, exp_a[i]);
            end
        end
        n_checks++;
        if ({done, zero_cnt, ones_cnt, max_zrun} !== {1'b1, 8'd6, 8'd2, 8'd5}) begin
            n_fail++;
            $display("FAIL alarm_stats: got d=%b z=%0d o=%0d m=%0d expected d=1 z=6 o=2 m=5",
                     done, zero_cnt, ones_cnt, max_zrun);
        end
        repeat (2) tick();
        n_checks++;
        if ({busy, run_alarm} !== 2'b01) begin
            n_fail++;
            $display("FAIL alarm_sticky_idle: got %b expected 01", {busy, run_alarm});
        end
    endtask

    task automatic test_backpressure();
        logic       vld   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] dat   [6] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        logic [7:0] exp_o [6] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
        logic [7:0] exp_z [6] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        logic       exp_d [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_start(8'd3);
        for (int i = 0; i < 6; i++) begin
            in_valid = vld[i];
            in_data  = dat[i];
            tick();
            n_checks++;
            if ({ones_cnt, zero_cnt, done} !== {exp_o[i], exp_z[i], exp_d[i]}) begin
                n_fail++;
                $display("FAIL backpressure_cycle%0d: got o=%0d z=%0d d=%b expected o=%0d z=%0d d=%b",
                         i, ones_cnt, zero_cnt, done, exp_o[i], exp_z[i], exp_d[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_len_zero();
        in_valid = 1'b1;
        in_data  = 8'h00;
        do_start(8'd0);
        n_checks++;
        if ({done, busy, in_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL len0_report: got %b expected 110", {done, busy, in_ready});
        end
        n_checks++;
        if ({zero_cnt, ones_cnt, max_zrun} !== 24'h0) begin
            n_fail++;
            $display("FAIL len0_stats: got %h expected 000000", {zero_cnt, ones_cnt, max_zrun});
        end
        tick();
        n_checks++;
        if ({done, busy, in_ready, zero_cnt} !== {3'b000, 8'd0}) begin
            n_fail++;
            $display("FAIL len0_idle: got d=%b b=%b r=%b z=%0d expected all 0",
                     done, busy, in_ready, zero_cnt);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_start_ignored();
        do_start(8'd3);
        send_byte(8'h00);
        start    = 1'b1;
        len      = 8'd1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        start    = 1'b0;
        n_checks++;
        if ({done, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL midstart_len_kept: got d=%b r=%b expected d=0 r=1", done, in_ready);
        end
        start    = 1'b1;
        len      = 8'd0;
        in_data  = 8'h00;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({done, zero_cnt, ones_cnt, max_zrun} !== {1'b1, 8'd2, 8'd1, 8'd1}) begin
            n_fail++;
            $display("FAIL midstart_stats: got d=%b z=%0d o=%0d m=%0d expected d=1 z=2 o=1 m=1",
                     done, zero_cnt, ones_cnt, max_zrun);
        end
        tick();
        n_checks++;
        if ({busy, zero_cnt} !== {1'b0, 8'd2}) begin
            n_fail++;
            $display("FAIL laststart_ignored: got b=%b z=%0d expected b=0 z=2", busy, zero_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_start(8'd1);
        send_byte(8'hFF);
        tick();
        n_checks++;
        if ({busy, ones_cnt} !== {1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL b2b_first_frame: got b=%b o=%0d expected b=0 o=1", busy, ones_cnt);
        end
        do_start(8'd2);
        n_checks++;
        if ({in_ready, ones_cnt} !== {1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL b2b_cleared: got r=%b o=%0d expected r=1 o=0", in_ready, ones_cnt);
        end
        send_byte(8'h00);
        send_byte(8'hEB);
        n_checks++;
        if ({done, zero_cnt, ones_cnt, max_zrun} !== {1'b1, 8'd1, 8'd0, 8'd1}) begin
            n_fail++;
            $display("FAIL b2b_second_stats: got d=%b z=%0d o=%0d m=%0d expected d=1 z=1 o=0 m=1",
                     done, zero_cnt, ones_cnt, max_zrun);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_start(8'd5);
        send_byte(8'h00);
        send_byte(8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, in_ready, done, zero_cnt, max_zrun} !== {3'b000, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL async_reset_now: got b=%b r=%b d=%b z=%0d m=%0d expected all 0",
                     busy, in_ready, done, zero_cnt, max_zrun);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL async_no_done_c%0d: got %b expected 00", i, {done, busy});
            end
        end
        do_start(8'd2);
        send_byte(8'h00);
        send_byte(8'h00);
        n_checks++;
        if ({done, zero_cnt, max_zrun} !== {1'b1, 8'd2, 8'd2}) begin
            n_fail++;
            $display("FAIL async_next_frame: got d=%b z=%0d m=%0d expected d=1 z=2 m=2",
                     done, zero_cnt, max_zrun);
        end
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = 8'd0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        test_reset();
        test_mixed();
        test_alarm();
        test_backpressure();
        test_len_zero();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
